pwm_multi: RTL and testbench

PWM_MULTI -- requirements
Module: pwm_multi

---
 rtl/pwm_multi.sv | 129 ++++++++++++
 tb/tb_pwm_multi.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi.sv
// Multi-channel PWM with a shared prescaled edge- or center-aligned counter
// and per-channel duty shadow registers that are committed at each period boundary.
module pwm_multi #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int PRESC_W  = 8,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                en_i,
  input  logic                mode_i,
  input  logic [PRESC_W-1:0]  presc_i,
  input  logic [WIDTH-1:0]    period_i,
  input  logic [CHANNELS-1:0] pol_i,
  input  logic                wr_valid_i,
  output logic                wr_ready_o,
  input  logic [CW-1:0]       wr_chan_i,
  input  logic [WIDTH-1:0]    wr_duty_i,
  output logic [CHANNELS-1:0] pwm_o,
  output logic                boundary_o,
  output logic [WIDTH-1:0]    cnt_o
);

  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  logic [PRESC_W-1:0]  presc_q;
  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    period_act;
  dir_t                dir_q, dir_d;
  logic                boundary_q;
  logic [CHANNELS-1:0] pwm_q;
  logic [CHANNELS-1:0] pend_q;
  logic [WIDTH-1:0]    duty_act  [CHANNELS];
  logic [WIDTH-1:0]    duty_pend [CHANNELS];
  logic                tick, wrap, ready, accept;

  assign tick = en_i && (presc_q == presc_i);

  // Out-of-range channel numbers never match, so such writes see ready high and are dropped.
  always_comb begin
    ready = 1'b1;
    for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
      if (en_i && pend_q[ch] && (wr_chan_i == CW'(ch))) ready = 1'b0;
    end
  end

  assign accept = wr_valid_i && ready;

  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    wrap  = 1'b0;
    if (!mode_i) begin
      dir_d = DIR_UP;
      if (tick) begin
        if (cnt_q >= period_act) begin
          cnt_d = '0;
          wrap  = 1'b1;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
    end else if (tick) begin
      if (dir_q == DIR_UP && cnt_q < period_act) begin
        cnt_d = cnt_q + WIDTH'(1);
      end else if (cnt_q == '0) begin
        // Degenerate period of 0: the counter sits at 0 and every tick is a boundary.
        wrap  = 1'b1;
        dir_d = DIR_UP;
      end else begin
        cnt_d = cnt_q - WIDTH'(1);
        dir_d = DIR_DOWN;
        if (cnt_q == WIDTH'(1)) begin
          wrap  = 1'b1;
          dir_d = DIR_UP;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      presc_q    <= '0;
      cnt_q      <= '0;
      dir_q      <= DIR_UP;
      period_act <= '0;
      boundary_q <= 1'b0;
      pwm_q      <= '0;
      pend_q     <= '0;
      for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
        duty_act[ch]  <= '0;
        duty_pend[ch] <= '0;
      end
    end else begin
      if (!en_i) begin
        presc_q    <= '0;
        cnt_q      <= '0;
        dir_q      <= DIR_UP;
        period_act <= period_i;
        boundary_q <= 1'b0;
      end else begin
        presc_q    <= tick ? '0 : presc_q + PRESC_W'(1);
        cnt_q      <= cnt_d;
        dir_q      <= dir_d;
        boundary_q <= wrap;
        if (wrap) period_act <= period_i;
      end
      // Commit before accept so a write landing in the commit cycle stays pending.
      for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
        if ((!en_i || wrap) && pend_q[ch]) begin
          duty_act[ch] <= duty_pend[ch];
          pend_q[ch]   <= 1'b0;
        end
        if (accept && (wr_chan_i == CW'(ch))) begin
          duty_pend[ch] <= wr_duty_i;
          pend_q[ch]    <= 1'b1;
        end
        pwm_q[ch] <= en_i ? ((cnt_q < duty_act[ch]) ^ pol_i[ch]) : pol_i[ch];
      end
    end
  end

  assign wr_ready_o = ready;
  assign pwm_o      = pwm_q;
  assign boundary_o = boundary_q;
  assign cnt_o      = cnt_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: a table of steady-state windows plus
// hand-written shadow-write and mid-period reset sequences.
module tb_pwm_multi;

  logic       clk = 1'b0;
  logic       rstn;
  logic       en, mode;
  logic [7:0] presc, period;
  logic [3:0] pol;
  logic       wr_valid, wr_ready;
  logic [1:0] wr_chan;
  logic [7:0] wr_duty;
  logic [3:0] pwm;
  logic       boundary;
  logic [7:0] cnt;

  int tests = 0;
  int fails = 0;

  pwm_multi #(.CHANNELS(4), .WIDTH(8), .PRESC_W(8)) dut (
    .clk_i(clk), .rstn_i(rstn), .en_i(en), .mode_i(mode), .presc_i(presc),
    .period_i(period), .pol_i(pol), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .wr_chan_i(wr_chan), .wr_duty_i(wr_duty), .pwm_o(pwm), .boundary_o(boundary),
    .cnt_o(cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       mode;
    logic [7:0] presc;
    logic [7:0] period;
    logic       pol;
    logic [7:0] duty;
    int         warm;
    int         win;
    int         exp_high;
    int         exp_bnd;
    int         exp_cmax;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rstn = 1'b0;
    #2 rstn = 1'b1;
    step();
  endtask

  task automatic setup(input logic m, input logic [7:0] ps, input logic [7:0] per,
                       input logic p, input logic [7:0] d);
    en = 1'b0; mode = m; presc = ps; period = per; pol = {3'b000, p};
    wr_valid = 1'b0; wr_chan = 2'd0; wr_duty = '0;
    do_reset();
    wr_valid = 1'b1; wr_duty = d;
    step();
    wr_valid = 1'b0;
    step();
    step();
  endtask

  initial begin
    int h, b, cm, early, found, lows;

    vecs[0] = '{1'b1, 1'b0, 8'd0, 8'd9, 1'b0, 8'd3,   10, 20,  6, 2, 9};
    vecs[1] = '{1'b1, 1'b1, 8'd1, 8'd4, 1'b0, 8'd2,   16, 32, 12, 2, 4};
    vecs[2] = '{1'b1, 1'b0, 8'd0, 8'd9, 1'b0, 8'd0,   10, 20,  0, 2, 9};
    vecs[3] = '{1'b1, 1'b0, 8'd0, 8'd9, 1'b0, 8'd255, 10, 20, 20, 2, 9};
    vecs[4] = '{1'b1, 1'b0, 8'd0, 8'd9, 1'b1, 8'd3,   10, 20, 14, 2, 9};
    vecs[5] = '{1'b1, 1'b0, 8'd0, 8'd9, 1'b1, 8'd255, 10, 20,  0, 2, 9};
    vecs[6] = '{1'b0, 1'b0, 8'd0, 8'd9, 1'b1, 8'd3,    5, 20, 20, 0, 0};
    vecs[7] = '{1'b1, 1'b0, 8'd2, 8'd4, 1'b0, 8'd2,   15, 30, 12, 2, 4};
    vecs[8] = '{1'b1, 1'b1, 8'd0, 8'd3, 1'b0, 8'd1,    6, 12,  2, 2, 3};
    vecs[9] = '{1'b1, 1'b1, 8'd0, 8'd4, 1'b0, 8'd5,    8, 16, 16, 2, 4};

    rstn = 1'b0; en = 1'b0; mode = 1'b0; presc = '0; period = '0; pol = '0;
    wr_valid = 1'b0; wr_chan = '0; wr_duty = '0;
    #3;
    check("reset pwm", int'(pwm), 0);
    check("reset cnt", int'(cnt), 0);
    check("reset boundary", int'(boundary), 0);
    check("reset ready", int'(wr_ready), 1);
    #2 rstn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      setup(vecs[i].mode, vecs[i].presc, vecs[i].period, vecs[i].pol, vecs[i].duty);
      en = vecs[i].en;
      for (int k = 0; k < vecs[i].warm; k++) step();
      h = 0; b = 0; cm = 0;
      for (int k = 0; k < vecs[i].win; k++) begin
        step();
        h += int'(pwm[0]);
        b += int'(boundary);
        if (int'(cnt) > cm) cm = int'(cnt);
      end
      check($sformatf("v%0d high", i), h, vecs[i].exp_high);
      check($sformatf("v%0d boundary", i), b, vecs[i].exp_bnd);
      check($sformatf("v%0d cnt_max", i), cm, vecs[i].exp_cmax);
    end

    // Shadow write: duty 3 running, write 7 mid-period, then a second write of 5.
    setup(1'b0, 8'd0, 8'd9, 1'b0, 8'd3);
    en = 1'b1;
    repeat (4) step();
    wr_valid = 1'b1; wr_duty = 8'd7;
    step();
    check("shadow ready low", int'(wr_ready), 0);
    wr_duty = 8'd5;
    early = 0; found = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (boundary) begin
        found = 1;
        break;
      end
      if (wr_ready) early = 1;
    end
    check("shadow boundary seen", found, 1);
    check("shadow ready held low", early, 0);
    check("shadow ready at boundary", int'(wr_ready), 1);
    step();
    h = int'(pwm[0]);
    check("second write accepted", int'(wr_ready), 0);
    wr_valid = 1'b0;
    repeat (9) begin
      step();
      h += int'(pwm[0]);
    end
    check("shadow duty7 high", h, 7);
    h = 0;
    repeat (10) begin
      step();
      h += int'(pwm[0]);
    end
    check("shadow duty5 high", h, 5);

    // Reset mid-period with a write still pending.
    setup(1'b0, 8'd0, 8'd9, 1'b1, 8'd3);
    en = 1'b1;
    repeat (5) step();
    wr_valid = 1'b1; wr_duty = 8'd8;
    step();
    wr_valid = 1'b0;
    check("rst pending set", int'(wr_ready), 0);
    repeat (2) step();
    check("rst pre pwm", int'(pwm[0]), 1);
    #2 rstn = 1'b0;
    #1;
    check("rst async pwm", int'(pwm), 0);
    check("rst async cnt", int'(cnt), 0);
    check("rst async boundary", int'(boundary), 0);
    #2 rstn = 1'b1;
    step();
    check("rst pending gone", int'(wr_ready), 1);
    repeat (3) step();
    lows = 0;
    repeat (25) begin
      step();
      lows += int'(!pwm[0]);
    end
    check("rst duty zero", lows, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
